// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port RAM arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int DEF_ADR_W  = 6;
  localparam int DEF_DATA_W = 8;
  localparam int LAT_CNT_W  = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin winner select and last-grant update
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       advance,
  output logic       winner,
  output logic       last_next
);

  // A lone requester wins outright; on a tie the port that was not granted last wins.
  always_comb begin
    winner = last;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = last;
    endcase
    last_next = advance ? winner : last;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one RAM between two req/ack masters
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADR_W  = DEF_ADR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADR_W-1:0]  adr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADR_W-1:0]  adr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read_en,
  output logic [ADR_W-1:0]  mem_read_adr,
  output logic              mem_write_en,
  output logic [ADR_W-1:0]  mem_write_adr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  // Counter preload so the last WAIT cycle is the one where the count reaches zero.
  localparam logic [LAT_CNT_W-1:0] WAIT_INIT =
    (RD_LAT > 0) ? LAT_CNT_W'(RD_LAT - 1) : '0;

  arb_state_t           state;
  logic                 last;
  logic                 winner;
  logic                 last_next;
  logic                 advance;
  logic                 cmd_we;
  logic                 cmd_id;
  logic [LAT_CNT_W-1:0] cnt;
  logic                 sel_we;
  logic [ADR_W-1:0]     sel_adr;
  logic [DATA_W-1:0]    sel_wdata;

  assign advance   = (state == IDLE) && (req0 || req1);
  assign sel_we    = winner ? we1 : we0;
  assign sel_adr   = winner ? adr1 : adr0;
  assign sel_wdata = winner ? wdata1 : wdata0;

  rr_arb2 u_rr (
    .req       ({req1, req0}),
    .last      (last),
    .advance   (advance),
    .winner    (winner),
    .last_next (last_next)
  );

  // Arbiter FSM: latch the winning command, strobe the RAM once, wait out the read latency, ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      last           <= 1'b1;
      cmd_we         <= 1'b0;
      cmd_id         <= 1'b0;
      cnt            <= '0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      mem_read_en    <= 1'b0;
      mem_read_adr   <= '0;
      mem_write_en   <= 1'b0;
      mem_write_adr  <= '0;
      mem_write_data <= '0;
      busy           <= 1'b0;
    end else begin
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      last         <= last_next;
      case (state)
        IDLE: begin
          if (advance) begin
            cmd_we <= sel_we;
            cmd_id <= winner;
            busy   <= 1'b1;
            state  <= ACCESS;
            if (sel_we) begin
              mem_write_en   <= 1'b1;
              mem_write_adr  <= sel_adr;
              mem_write_data <= sel_wdata;
            end else begin
              mem_read_en  <= 1'b1;
              mem_read_adr <= sel_adr;
            end
          end
        end
        ACCESS: begin
          if (cmd_we || RD_LAT == 0) begin
            if (!cmd_we) begin
              if (cmd_id) rdata1 <= mem_read_data;
              else        rdata0 <= mem_read_data;
            end
            ack0  <= ~cmd_id;
            ack1  <= cmd_id;
            state <= RESP;
          end else begin
            cnt   <= WAIT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (cmd_id) rdata1 <= mem_read_data;
            else        rdata0 <= mem_read_data;
            ack0  <= ~cmd_id;
            ack1  <= cmd_id;
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req0, we0, req1, we1;
  logic [5:0] adr0, adr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, re, we, busy;
  logic [7:0] rdata0, rdata1, mwd, mrd;
  logic [5:0] radr, wadr;

  mem_arbiter #(.ADR_W(6), .DATA_W(8), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .adr0(adr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .adr1(adr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_read_en(re), .mem_read_adr(radr), .mem_write_en(we), .mem_write_adr(wadr),
    .mem_write_data(mwd), .mem_read_data(mrd), .busy(busy)
  );

  logic       l0_req, l0_ack0, l0_ack1, l0_re, l0_we, l0_busy;
  logic [7:0] l0_rdata0, l0_rdata1, l0_wdata, l0_rd;
  logic [5:0] l0_radr, l0_wadr;
  logic       l3_req, l3_ack0, l3_ack1, l3_re, l3_we, l3_busy;
  logic [7:0] l3_rdata0, l3_rdata1, l3_wdata, l3_rd;
  logic [5:0] l3_radr, l3_wadr;
  logic [5:0] lat_adr = 6'd42;

  mem_arbiter #(.ADR_W(6), .DATA_W(8), .RD_LAT(0)) u_lat0 (
    .clk(clk), .reset(reset),
    .req0(l0_req), .we0(1'b0), .adr0(lat_adr), .wdata0(8'h00), .ack0(l0_ack0), .rdata0(l0_rdata0),
    .req1(1'b0), .we1(1'b0), .adr1(6'd0), .wdata1(8'h00), .ack1(l0_ack1), .rdata1(l0_rdata1),
    .mem_read_en(l0_re), .mem_read_adr(l0_radr), .mem_write_en(l0_we), .mem_write_adr(l0_wadr),
    .mem_write_data(l0_wdata), .mem_read_data(l0_rd), .busy(l0_busy)
  );

  mem_arbiter #(.ADR_W(6), .DATA_W(8), .RD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .req0(l3_req), .we0(1'b0), .adr0(lat_adr), .wdata0(8'h00), .ack0(l3_ack0), .rdata0(l3_rdata0),
    .req1(1'b0), .we1(1'b0), .adr1(6'd0), .wdata1(8'h00), .ack1(l3_ack1), .rdata1(l3_rdata1),
    .mem_read_en(l3_re), .mem_read_adr(l3_radr), .mem_write_en(l3_we), .mem_write_adr(l3_wadr),
    .mem_write_data(l3_wdata), .mem_read_data(l3_rd), .busy(l3_busy)
  );

  // RAM models: data is only valid RD_LAT cycles after an enabled read, otherwise zero.
  logic [7:0] ram [64];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (we) ram[wadr] <= mwd;
    ram_q <= re ? ram[radr] : 8'h00;
  end
  assign mrd = ram_q;

  logic [7:0] ram_l0 [64];
  assign l0_rd = l0_re ? ram_l0[l0_radr] : 8'h00;

  logic [7:0] ram_l3 [64];
  logic [7:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= l3_re ? ram_l3[l3_radr] : 8'h00;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign l3_rd = p3[2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int ack0_cnt = 0, ack_both = 0, en_both = 0, re_cyc = 0, we_cyc = 0;
  logic [5:0] seen_radr, seen_wadr;
  logic [7:0] seen_wdata;

  always @(negedge clk) begin
    if (ack0) ack0_cnt++;
    if (ack0 && ack1) ack_both++;
    if (re && we) en_both++;
    if (re) begin re_cyc++; seen_radr = radr; end
    if (we) begin we_cyc++; seen_wadr = wadr; seen_wdata = mwd; end
  end

  // One transaction on the RD_LAT=1 DUT; lat counts edges after the sampling edge until ack shows.
  task automatic txn(input bit p, input logic w, input logic [5:0] a, input logic [7:0] d,
                     output int lat);
    @(negedge clk);
    re_cyc = 0;
    we_cyc = 0;
    if (!p) begin req0 = 1'b1; we0 = w; adr0 = a; wdata0 = d; end
    else    begin req1 = 1'b1; we1 = w; adr1 = a; wdata1 = d; end
    lat = -1;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((!p && ack0) || (p && ack1)) begin lat = i; break; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Both ports read together; port 0 issues reps0 back-to-back transactions. Grant order as digits.
  task automatic tie(input logic [5:0] a0, input logic [5:0] a1, input int reps0, output int code);
    int n0 = 0;
    code = 0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; adr0 = a0;
    req1 = 1'b1; we1 = 1'b0; adr1 = a1;
    for (int i = 0; i < 40 && (req0 || req1); i++) begin
      @(negedge clk);
      if (ack0) begin code = code * 10 + 1; n0++; if (n0 >= reps0) req0 = 1'b0; end
      if (ack1) begin code = code * 10 + 2; req1 = 1'b0; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic lat_read(input bit sel3, output int lat, output logic [7:0] d);
    @(negedge clk);
    if (sel3) l3_req = 1'b1; else l0_req = 1'b1;
    lat = -1;
    d = 8'h00;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sel3 ? l3_ack0 : l0_ack0) begin
        lat = i;
        d = sel3 ? l3_rdata0 : l0_rdata0;
        break;
      end
    end
    l0_req = 1'b0;
    l3_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int lat;
    int code;
    logic [7:0] d;
    reset = 1'b0;
    req0 = 1'b0; we0 = 1'b0; adr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; adr1 = '0; wdata1 = '0;
    l0_req = 1'b0; l3_req = 1'b0;
    ram_l0[42] = 8'hC3;
    ram_l3[42] = 8'h9D;
    repeat (2) @(negedge clk);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_busy", busy, 0);
    check("rst_re", re, 0);
    check("rst_we", we, 0);
    check("rst_rdata0", rdata0, 0);
    reset = 1'b1;

    txn(0, 1'b1, 6'h05, 8'hA5, lat);
    check("wr0_lat", lat, 1);
    check("wr0_we_cycles", we_cyc, 1);
    check("wr0_re_cycles", re_cyc, 0);
    check("wr0_adr", seen_wadr, 6'h05);
    check("wr0_data", seen_wdata, 8'hA5);

    txn(1, 1'b0, 6'h05, 8'h00, lat);
    check("rd1_lat", lat, 2);
    check("rd1_re_cycles", re_cyc, 1);
    check("rd1_we_cycles", we_cyc, 0);
    check("rd1_adr", seen_radr, 6'h05);
    check("rd1_data", rdata1, 8'hA5);

    txn(1, 1'b1, 6'h06, 8'h66, lat);
    check("wr1_lat", lat, 1);

    do_reset();
    tie(6'h05, 6'h06, 2, code);
    check("tieA_order", code, 121);
    check("tieA_rdata0", rdata0, 8'hA5);
    check("tieA_rdata1", rdata1, 8'h66);

    txn(1, 1'b1, 6'h3F, 8'h3C, lat);
    check("wr3f_lat", lat, 1);

    tie(6'h06, 6'h05, 1, code);
    check("tieB_order", code, 12);
    check("tieB_rdata0", rdata0, 8'h66);
    check("tieB_rdata1", rdata1, 8'hA5);

    // Reset landing in ACCESS must drop the read strobe at once.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; adr0 = 6'h05;
    @(posedge clk);
    @(negedge clk);
    check("acc_re", re, 1);
    #2 reset = 1'b0;
    #1 check("acc_rst_re", re, 0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Reset landing in WAIT: everything clears, no ack follows.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; adr0 = 6'h05;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("wait_busy", busy, 1);
    rdata0_before_check: begin end
    #2 reset = 1'b0;
    #1;
    check("wrst_busy", busy, 0);
    check("wrst_ack0", ack0, 0);
    check("wrst_rdata0", rdata0, 0);
    check("wrst_rdata1", rdata1, 0);
    check("wrst_radr", radr, 0);
    check("wrst_wadr", wadr, 0);
    check("wrst_wdata", mwd, 0);
    req0 = 1'b0;
    ack0_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("wrst_no_ack", ack0_cnt, 0);

    txn(0, 1'b0, 6'h3F, 8'h00, lat);
    check("post_rst_lat", lat, 2);
    check("post_rst_data", rdata0, 8'h3C);

    lat_read(0, lat, d);
    check("lat0_lat", lat, 1);
    check("lat0_data", d, 8'hC3);
    lat_read(1, lat, d);
    check("lat3_lat", lat, 4);
    check("lat3_data", d, 8'h9D);

    check("ack_overlap", ack_both, 0);
    check("en_overlap", en_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
